instruction_fetch_queue: RTL and testbench
==========================================

Name: instruction_fetch_queue

Overview:
- Parametrised successor to the single-register IF stage.
- Decouples PC generation from instruction memory with a valid/ready request port that tolerates variable latency, and a DEPTH-entry prefetch queue holding {pc, instruction} pairs.
- Presents the queue head to ID through a valid/ready handshake.
- On a JUMP/TRAP redirect it flushes the queue and discards responses still in flight.

Parameters:
- XLEN, 32: PC/address width.
- ILEN, 32: instruction width.
- DEPTH, 4: prefetch queue entries. Power of two, >=2.
- RESET_PC, 0: fetch PC after reset.

Ports:
- clk  in  1: clock.
- rst  in  1: synchronous reset, active-high.
- clk_en  in  1: clock enable. When 0, all state holds.
- pc_sel  in  2: nextPCType_e (PC_PLUS4, JUMP, TRAP). Other codes act as PC_PLUS4.
- jump_addr  in  XLEN: redirect target when pc_sel=JUMP.
- trap_addr  in  XLEN: redirect target when pc_sel=TRAP.
- mem_req_valid  out  1: fetch request valid.
- mem_req_ready  in  1: memory accepts the request.
- mem_req_addr  out  XLEN: fetch address.
- mem_rsp_valid  in  1: response valid. In order, at least 1 cycle after acceptance.
- mem_rsp_data  in  ILEN: fetched instruction.
- id_valid  out  1: queue head valid.
- id_ready  in  1: ID consumes the head.
- inst_id  out  ILEN: head instruction. 0 when empty.
- pc_id  out  XLEN: head PC. 0 when empty.

Behaviour:
- State:
  - fetch_pc.
  - Queue with count and rd/wr pointers (wrap modulo DEPTH).
  - outstanding: accepted requests without a response, 0..DEPTH.
  - drop_cnt: responses still to be discarded, 0..DEPTH.
- Reset (rst=1 at clk edge, regardless of clk_en):
  - fetch_pc=RESET_PC; count=outstanding=drop_cnt=0.
  - Outputs are 0 while rst=1.
  - Mid-operation reset abandons in-flight requests. The memory must also be reset.
- Credit and requests:
  - credit = count + outstanding < DEPTH.
  - mem_req_valid = clk_en & credit & ~redirect & ~rst; mem_req_addr = fetch_pc.
  - Accept = valid & ready: fetch_pc += 4 (wraps mod 2^XLEN), outstanding+1.
  - Once raised, valid and addr stay stable until accepted. The only exception is a redirect, which may drop or change them.
- Responses:
  - Each response decrements outstanding.
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Otherwise push {pc, mem_rsp_data}. The pushed pc is tracked by a rsp_pc register: set to the redirect target / RESET_PC, +4 per pushed response.
  - The credit scheme guarantees no push when full. Push while full is an assertion failure.
- ID side:
  - id_valid = count!=0.
  - Pop on id_valid & id_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Latency: acceptance-to-response is memory latency; response-to-id_valid is 1 cycle (no bypass).
- Redirect (pc_sel=JUMP or TRAP, with clk_en=1):
  - fetch_pc and rsp_pc take the target.
  - Queue cleared (count=0, pointers reset). Any same-cycle pop is ignored.
  - No request accepted that cycle.
  - drop_cnt = outstanding − (mem_rsp_valid ? 1 : 0). A same-cycle response is discarded.
  - A redirect while drop_cnt>0 recomputes drop_cnt by the same rule.
- clk_en=0:
  - No state change; mem_req_valid=0.
  - Memory must not assert mem_rsp_valid (assertion).
- Back-to-back: with zero memory stall and id_ready=1, one instruction per cycle is sustained.

Optional Feature:
- Macro: IF_MISALIGN_TRAP_EN.
- Defined:
  - Extra outputs misalign_trap (1) and misalign_addr (XLEN), both reset 0.
  - A redirect whose target[1:0]!=0 sets misalign_trap=1 with misalign_addr=target the next cycle.
  - Fetching stays stalled (mem_req_valid=0) until the next redirect. That redirect clears misalign_trap.
- Undefined:
  - Ports absent; target[1:0] forced to 0.

Test Plan:
- Reset, RESET_PC=0x100, 1-cycle memory, id_ready=1 -> requests 0x100, 0x104, 0x108…; id_valid first at cycle 3 after reset release; pc_id follows 0x100, 0x104…, one per cycle.
- id_ready=0, DEPTH=4 -> exactly 4 requests accepted, then mem_req_valid=0. id_ready=1 for one cycle -> one pop, one new request to 0x110.
- mem_req_ready low for 3 cycles -> mem_req_addr held at 0x108, no fetch_pc advance, no queue corruption.
- 3 outstanding with 4-cycle latency, JUMP to 0x400 -> queue empties next cycle; the 3 stale responses are discarded (drop_cnt 3→0); first pc_id=0x400 with its correct instruction.
- TRAP with a response arriving the same cycle -> that response is discarded and drop_cnt = outstanding−1; trap_addr is fetched next.
- clk_en=0 for 5 cycles mid-stream -> all outputs frozen, mem_req_valid=0; resume without loss. With IF_MISALIGN_TRAP_EN, JUMP to 0x402 -> misalign_trap=1, misalign_addr=0x402, no requests.

Source files
------------

// File: rtl/instruction_fetch_queue.sv
// -----------------------------------------------------------------------------
// instruction_fetch_queue
//
// Purpose:
//   Prefetching instruction fetch stage. It generates fetch PCs and issues them
//   to instruction memory over a valid/ready request port that tolerates any
//   response latency of at least one cycle. Responses land in a DEPTH-entry
//   queue of {pc, instruction} pairs. The queue head is presented to ID through
//   a valid/ready handshake.
//
//   A JUMP or TRAP redirect does four things:
//     - flushes the queue;
//     - retargets the fetch PC;
//     - blocks request acceptance for that cycle;
//     - arms a drop counter, so that responses to requests issued before the
//       redirect are discarded.
//
//   Requests are only issued while count + outstanding < DEPTH. Because of
//   this credit rule, every response always has a queue slot waiting for it.
//
// Parameters:
//   XLEN      PC / address width
//   ILEN      instruction width
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   clk_en                global enable; when low all state holds
//   pc_sel                0 = PC_PLUS4, 1 = JUMP, 2 = TRAP, 3 acts as PC_PLUS4
//   jump_addr, trap_addr  redirect targets
//   mem_req_*             fetch request (valid/ready, address)
//   mem_rsp_*             in-order fetch response (valid, data)
//   id_valid, id_ready    head-of-queue handshake towards ID
//   inst_id, pc_id        head entry; zero when the queue is empty
//
// Optional feature (macro IF_MISALIGN_TRAP_EN):
//   When the macro is defined:
//     - a redirect to a target with target[1:0] != 0 raises misalign_trap
//       and captures the target in misalign_addr;
//     - fetching then stalls until the next redirect, which clears the trap.
//   When the macro is undefined:
//     - the misalign ports are absent;
//     - redirect targets are forced word aligned.
// -----------------------------------------------------------------------------
module instruction_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    input  logic [1:0]      pc_sel,
    input  logic [XLEN-1:0] jump_addr,
    input  logic [XLEN-1:0] trap_addr,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [ILEN-1:0] mem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [ILEN-1:0] inst_id,
    output logic [XLEN-1:0] pc_id
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic            misalign_trap,
    output logic [XLEN-1:0] misalign_addr
`endif
);

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        JUMP     = 2'd1,
        TRAP     = 2'd2
    } next_pc_type_e;

    localparam int PTR_W = $clog2(DEPTH);
    // Counters must be able to hold the value DEPTH itself.
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   DEPTH_S = DEPTH[CNT_W:0];
    localparam logic [CNT_W-1:0] DEPTH_C = DEPTH[CNT_W-1:0];
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);

    // Queue storage and pointers.
    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic [ILEN-1:0]  inst_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    // Fetch-side state.
    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  rsp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [CNT_W-1:0] drop_cnt;

    // Per-cycle control.
    logic             redirect;
    logic [XLEN-1:0]  target_raw;
    logic [XLEN-1:0]  target;
    logic             fetch_stall;
    logic [CNT_W:0]   occupancy;
    logic             credit;
    logic             accept;
    logic             rsp_fire;
    logic             push;
    logic             pop;
    logic             head_valid;

    assign redirect   = clk_en & ((pc_sel == JUMP) | (pc_sel == TRAP));
    assign target_raw = (pc_sel == TRAP) ? trap_addr : jump_addr;

`ifdef IF_MISALIGN_TRAP_EN
    logic            target_misaligned;
    logic            misalign_q;
    logic [XLEN-1:0] misalign_addr_q;

    assign target            = target_raw;
    assign target_misaligned = |target_raw[1:0];
    assign fetch_stall       = misalign_q;
    assign misalign_trap     = ~rst & misalign_q;
    assign misalign_addr     = rst ? '0 : misalign_addr_q;
`else
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    assign target      = target_raw & ALIGN_MASK;
    assign fetch_stall = 1'b0;
`endif

    // In-flight requests count against capacity, so a response never finds
    // the queue full.
    assign occupancy = {1'b0, count} + {1'b0, outstanding};
    assign credit    = occupancy < DEPTH_S;

    assign mem_req_valid = ~rst & clk_en & credit & ~redirect & ~fetch_stall;
    assign mem_req_addr  = rst ? '0 : fetch_pc;
    assign accept        = mem_req_valid & mem_req_ready;

    // A response is dropped in two cases: it arrives in the same cycle as a
    // redirect, or it belongs to the stale window counted by drop_cnt.
    assign rsp_fire = ~rst & clk_en & mem_rsp_valid;
    assign push     = rsp_fire & ~redirect & (drop_cnt == '0);

    assign head_valid = (count != '0);
    assign pop        = ~rst & clk_en & ~redirect & head_valid & id_ready;

    assign id_valid = ~rst & head_valid;
    assign inst_id  = id_valid ? inst_q[rd_ptr] : '0;
    assign pc_id    = id_valid ? pc_q[rd_ptr]   : '0;

    always_comb begin
        outstanding_nxt = outstanding;
        if (accept && !rsp_fire) begin
            outstanding_nxt = outstanding + CNT_ONE;
        end else if (!accept && rsp_fire) begin
            outstanding_nxt = outstanding - CNT_ONE;
        end
    end

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_ONE;
        end else if (!push && pop) begin
            count_nxt = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (clk_en) begin
            outstanding <= outstanding_nxt;
            if (redirect) begin
                fetch_pc <= target;
                rsp_pc   <= target;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                // Every request still in flight after this cycle predates the
                // redirect. A response arriving this cycle is already dropped.
                drop_cnt <= outstanding_nxt;
            end else begin
                count <= count_nxt;
                if (accept) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (rsp_fire && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CNT_ONE;
                end
                if (push) begin
                    rsp_pc <= rsp_pc + PC_STEP;
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
        end
    end

    // Queue payload needs no reset; head_valid qualifies every read.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]   <= rsp_pc;
            inst_q[wr_ptr] <= mem_rsp_data;
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else if (redirect) begin
            misalign_q <= target_misaligned;
            if (target_misaligned) begin
                misalign_addr_q <= target;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    a_no_push_when_full : assert property (
        @(posedge clk) disable iff (rst) !(push && (count == DEPTH_C))
    );
    a_no_rsp_while_gated : assert property (
        @(posedge clk) disable iff (rst) !(mem_rsp_valid && !clk_en)
    );
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;

    localparam int          XLEN   = 32;
    localparam int          ILEN   = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h100;

    logic              clk = 1'b0;
    logic              rst;
    logic              clk_en;
    logic [1:0]        pc_sel;
    logic [XLEN-1:0]   jump_addr;
    logic [XLEN-1:0]   trap_addr;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [XLEN-1:0]   mem_req_addr;
    logic              mem_rsp_valid;
    logic [ILEN-1:0]   mem_rsp_data;
    logic              id_valid;
    logic              id_ready;
    logic [ILEN-1:0]   inst_id;
    logic [XLEN-1:0]   pc_id;
`ifdef IF_MISALIGN_TRAP_EN
    logic              misalign_trap;
    logic [XLEN-1:0]   misalign_addr;
`endif

    instruction_fetch_queue #(
        .XLEN     (XLEN),
        .ILEN     (ILEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .pc_sel        (pc_sel),
        .jump_addr     (jump_addr),
        .trap_addr     (trap_addr),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .inst_id       (inst_id),
        .pc_id         (pc_id)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .misalign_trap (misalign_trap),
        .misalign_addr (misalign_addr)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: accepted requests waiting for their response cycle.
    // 'stale' marks requests issued before a later redirect.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    // Reference queue: what ID must see, oldest first.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    req_t        pend[$];
    ent_t        mq[$];
    logic [31:0] m_fetch_pc;
    bit          m_mis;
    logic [31:0] m_mis_addr;
    int          lat;
    int          cyc;
    int          n_cmp;
    int          n_err;

    bit          seen_id;
    int          mark_cyc;
    int          first_id_cyc;
    logic [31:0] first_pc;
    logic [31:0] first_inst;
    int          dut_acc;
    bit          hit;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle:
    //   1. drive the memory response;
    //   2. compare all outputs with the model at the falling edge;
    //   3. advance the model at the rising edge.
    task automatic step();
        bit          rsp;
        bit          redir;
        bit          e_rv;
        bit          e_iv;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        req_t        r;

        rsp           = !rst && clk_en && pend.size() > 0 && pend[0].due <= cyc;
        mem_rsp_valid = rsp;
        mem_rsp_data  = rsp ? mem_word(pend[0].addr) : 32'hDEAD_BEEF;
        redir         = clk_en && (pc_sel == 2'd1 || pc_sel == 2'd2);
        tgt           = (pc_sel == 2'd2) ? trap_addr : jump_addr;
`ifndef IF_MISALIGN_TRAP_EN
        tgt[1:0] = 2'b00;
`endif
        e_rv   = !rst && clk_en && !redir && !m_mis && (mq.size() + pend.size() < DEPTH);
        e_iv   = !rst && mq.size() != 0;
        e_pc   = 32'h0;
        e_inst = 32'h0;
        if (e_iv) begin
            e_pc   = mq[0].pc;
            e_inst = mq[0].inst;
        end

        @(negedge clk);
        check("mem_req_valid", mem_req_valid, e_rv);
        check("mem_req_addr", mem_req_addr, rst ? 32'h0 : m_fetch_pc);
        check("id_valid", id_valid, e_iv);
        check("pc_id", pc_id, e_pc);
        check("inst_id", inst_id, e_inst);
`ifdef IF_MISALIGN_TRAP_EN
        check("misalign_trap", misalign_trap, !rst && m_mis);
        if (!rst && m_mis) check("misalign_addr", misalign_addr, m_mis_addr);
`endif
        if (!seen_id && id_valid) begin
            seen_id      = 1;
            first_id_cyc = cyc - mark_cyc;
            first_pc     = pc_id;
            first_inst   = inst_id;
        end
        if (mem_req_valid && mem_req_ready) dut_acc++;

        @(posedge clk);
        if (rst) begin
            pend.delete();
            mq.delete();
            m_fetch_pc = RST_PC;
            m_mis      = 0;
        end else if (clk_en) begin
            if (rsp) r = pend.pop_front();
            if (redir) begin
                mq.delete();
                foreach (pend[i]) pend[i].stale = 1;
                m_fetch_pc = tgt;
`ifdef IF_MISALIGN_TRAP_EN
                m_mis = (tgt[1:0] != 2'b00);
                if (m_mis) m_mis_addr = tgt;
`endif
            end else begin
                if (e_iv && id_ready) void'(mq.pop_front());
                if (rsp && !r.stale) mq.push_back('{r.addr, mem_word(r.addr)});
                if (e_rv && mem_req_ready) begin
                    pend.push_back('{m_fetch_pc, cyc + lat, 1'b0});
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        rst           = 1;
        clk_en        = 1;
        pc_sel        = 2'd0;
        jump_addr     = '0;
        trap_addr     = '0;
        mem_req_ready = 1;
        id_ready      = 1;
        mem_rsp_valid = 0;
        mem_rsp_data  = '0;
        lat           = 1;
        cyc           = 0;
        n_cmp         = 0;
        n_err         = 0;
        m_fetch_pc    = RST_PC;
        m_mis         = 0;
        m_mis_addr    = '0;
        seen_id       = 0;
        mark_cyc      = 0;
        first_id_cyc  = -1;
        first_pc      = '0;
        first_inst    = '0;
        dut_acc       = 0;
        hit           = 0;
        @(posedge clk);
        #1;

        // Reset, then stream with 1-cycle memory: first ID on the third released cycle.
        step();
        step();
        rst      = 0;
        mark_cyc = cyc;
        seen_id  = 0;
        #1;
        check("first req valid", mem_req_valid, 1'b1);
        check("first req addr", mem_req_addr, 32'h100);
        repeat (12) step();
        check("first id cycle", first_id_cyc, 2);
        check("first pc_id", first_pc, 32'h100);
        check("first inst_id", first_inst, 32'h1357_9ADF);

        // ID stalled: exactly DEPTH requests, then one pop frees one credit.
        rst = 1;
        step();
        rst      = 0;
        id_ready = 0;
        dut_acc  = 0;
        repeat (8) step();
        check("accepts while stalled", dut_acc, 4);
        check("req blocked when full", mem_req_valid, 1'b0);
        check("full head pc", pc_id, 32'h100);
        id_ready = 1;
        step();
        id_ready = 0;
        #1;
        check("refill req valid", mem_req_valid, 1'b1);
        check("refill req addr", mem_req_addr, 32'h110);
        step();
        id_ready = 1;
        repeat (8) step();

        // Memory not ready for 3 cycles: request held.
        rst = 1;
        step();
        rst = 0;
        step();
        step();
        mem_req_ready = 0;
        for (int i = 0; i < 3; i++) begin
            check("held req valid", mem_req_valid, 1'b1);
            check("held req addr", mem_req_addr, 32'h108);
            step();
        end
        mem_req_ready = 1;
        repeat (8) step();

        // JUMP with 3 requests outstanding at 4-cycle latency.
        rst = 1;
        step();
        rst = 0;
        lat = 4;
        repeat (3) step();
        pc_sel    = 2'd1;
        jump_addr = 32'h400;
        step();
        pc_sel  = 2'd0;
        seen_id = 0;
        repeat (14) step();
        check("jump first pc", first_pc, 32'h400);
        check("jump first inst", first_inst, 32'h1357_9FDF);

        // TRAP in the same cycle as a response, with a non-empty queue.
        lat      = 2;
        id_ready = 0;
        hit      = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (pend.size() >= 2 && pend[0].due <= cyc && mq.size() > 0) begin
                pc_sel    = 2'd2;
                trap_addr = 32'h800;
                hit       = 1;
            end
            step();
            pc_sel = 2'd0;
        end
        check("trap scenario reached", hit, 1'b1);
        #1;
        check("trap flushed id", id_valid, 1'b0);
        check("trap req valid", mem_req_valid, 1'b1);
        check("trap req addr", mem_req_addr, 32'h800);
        id_ready = 1;
        seen_id  = 0;
        repeat (12) step();
        check("trap first pc", first_pc, 32'h800);

        // clk_en low for 5 cycles; a JUMP during the gap must be ignored.
        lat = 1;
        repeat (4) step();
        clk_en = 0;
        for (int i = 0; i < 5; i++) begin
            pc_sel    = (i == 2) ? 2'd1 : 2'd0;
            jump_addr = 32'h990;
            #1;
            check("gated req valid", mem_req_valid, 1'b0);
            step();
        end
        pc_sel = 2'd0;
        clk_en = 1;
        repeat (6) step();

        // pc_sel = 3 behaves as PC_PLUS4; then fetch PC wraps past 2^32.
        pc_sel = 2'd3;
        repeat (4) step();
        pc_sel    = 2'd1;
        jump_addr = 32'hFFFF_FFF8;
        step();
        pc_sel  = 2'd0;
        seen_id = 0;
        repeat (10) step();
        check("wrap first pc", first_pc, 32'hFFFF_FFF8);

`ifdef IF_MISALIGN_TRAP_EN
        pc_sel    = 2'd1;
        jump_addr = 32'h402;
        step();
        pc_sel = 2'd0;
        #1;
        check("misalign trap set", misalign_trap, 1'b1);
        check("misalign addr", misalign_addr, 32'h402);
        check("misalign stall", mem_req_valid, 1'b0);
        repeat (4) step();
        check("misalign still stalled", mem_req_valid, 1'b0);
        pc_sel    = 2'd1;
        jump_addr = 32'h500;
        step();
        pc_sel = 2'd0;
        #1;
        check("misalign cleared", misalign_trap, 1'b0);
        check("misalign resume addr", mem_req_addr, 32'h500);
        repeat (6) step();
`else
        pc_sel    = 2'd1;
        jump_addr = 32'h402;
        step();
        pc_sel = 2'd0;
        #1;
        check("aligned target addr", mem_req_addr, 32'h400);
        repeat (6) step();
`endif

        // Reset in mid-stream; the memory model is reset with it.
        rst = 1;
        step();
        rst = 0;
        #1;
        check("post reset addr", mem_req_addr, 32'h100);
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
